ps2_receiver: RTL

Synthesizable PS/2 device-to-host receiver for the keyboard path of the final-project design. Samples the open-collector `ps2_clk`/`ps2_data` pair in the system clock domain and deframes 11-bit PS/2 frames: start, 8 data bits LSB first, odd parity, stop. Validated scan codes are buffered in a small first-word-fall-through FIFO for the scan-code decoder. The bench keyboard model drives it directly.

---
 rtl/ps2_pkg.sv | 9 +
 rtl/ps2_sync_filter.sv | 31 +++
 rtl/ps2_receiver.sv | 113 +++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared FSM states, frame constants and parity helper for the PS/2 receiver
package ps2_pkg;
  typedef enum logic [1:0] {IDLE, RECV, CHECK} ps2_state_t;
  localparam int PS2_FRAME_BITS = 11;
  localparam int PS2_DATA_BITS = 8;
  function automatic logic odd_parity(input logic [PS2_DATA_BITS-1:0] d);
    return ~^d;
  endfunction
endpackage

// File: rtl/ps2_sync_filter.sv
// ps2_sync_filter: 2-FF synchronizer, level filter and falling-edge detector for one PS/2 line
module ps2_sync_filter #(
  parameter int FILTER_LEN = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic level,
  output logic fall
);
  localparam logic [3:0] LAST = 4'(FILTER_LEN - 1);
  logic       s0;
  logic [3:0] cnt;
  // level follows sync only after FILTER_LEN consecutive differing samples; fall marks the 1->0 flip
  always_ff @(posedge clk) begin
    if (rst) begin
      s0    <= 1'b1;
      sync  <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      fall  <= 1'b0;
    end else begin
      s0    <= din;
      sync  <= s0;
      cnt   <= (sync == level || cnt == LAST) ? '0 : cnt + 1'b1;
      level <= (sync != level && cnt == LAST) ? sync : level;
      fall  <= sync != level && cnt == LAST && level;
    end
  end
endmodule

// File: rtl/ps2_receiver.sv
// ps2_receiver: deframes PS/2 device frames and buffers validated scan codes in a FWFT FIFO
module ps2_receiver
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 2,
  parameter int TIMEOUT_CYCLES = 2000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rd_en,
  output logic [7:0] data_out,
  output logic       ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [AW:0] FULL_C = (AW + 1)'(FIFO_DEPTH);
  localparam logic [TW-1:0] TO_C = TW'(TIMEOUT_CYCLES);
  ps2_state_t state, state_n;
  logic fall, din;
  logic [3:0] cnt;
  logic [PS2_FRAME_BITS-2:0] frame;
  logic [TW-1:0] idle_cnt;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] count;
  logic timeout, bad_par, bad_stop, full, pop, wr, pe_n, fe_n, ov_n;

  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_clk (
    .clk(clk), .rst(rst), .din(ps2_clk), .sync(), .level(), .fall(fall)
  );
  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_data (
    .clk(clk), .rst(rst), .din(ps2_data), .sync(din), .level(), .fall()
  );

  assign timeout  = state == RECV && !fall && idle_cnt == TO_C;
  assign bad_par  = frame[8] != odd_parity(frame[7:0]);
  assign bad_stop = !frame[9];
  assign full     = count == FULL_C;
  assign ready    = |count;
  assign pop      = rd_en && ready;
  assign data_out = ready ? mem[rp] : 8'h00;

  // state register
  always_ff @(posedge clk) begin
    state <= rst ? IDLE : state_n;
  end

  // next state and the one-cycle CHECK verdict, errors taking priority over the FIFO write
  always_comb begin
    state_n = state;
    pe_n = 1'b0;
    fe_n = timeout;
    ov_n = 1'b0;
    wr = 1'b0;
    if (state == IDLE) begin
      state_n = (fall && !din) ? RECV : IDLE;
    end else if (state == RECV) begin
      state_n = timeout ? IDLE : (fall && cnt == 4'd9) ? CHECK : RECV;
    end else begin
      state_n = IDLE;
      pe_n = bad_par;
      fe_n = !bad_par && bad_stop;
      ov_n = !bad_par && !bad_stop && full && !rd_en;
      wr = !bad_par && !bad_stop && !(full && !rd_en);
    end
  end

  // bit capture (data, parity, stop by position) and inter-edge idle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      frame    <= '0;
      idle_cnt <= '0;
    end else begin
      idle_cnt <= (state != RECV || fall) ? '0 : idle_cnt + 1'b1;
      if (state == IDLE && fall && !din) cnt <= '0;
      else if (state == RECV && fall) begin
        frame[cnt] <= din;
        cnt        <= cnt + 1'b1;
      end
    end
  end

  // registered error pulses and FIFO pointers/occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
      wp         <= '0;
      rp         <= '0;
      count      <= '0;
    end else begin
      parity_err <= pe_n;
      frame_err  <= fe_n;
      overflow   <= ov_n;
      wp         <= wr ? wp + 1'b1 : wp;
      rp         <= pop ? rp + 1'b1 : rp;
      count      <= (wr && !pop) ? count + 1'b1 : (!wr && pop) ? count - 1'b1 : count;
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= frame[7:0];
  end
endmodule
